// File: rtl/uibi_interconnect.sv
// Round-robin switch between N_MASTER bus masters and N_SLAVE slaves of the internal bus.
// Times out hung slaves and answers unmapped targets with an error completion.
//
// state | meaning
// IDLE  | arbitrate among requesters, latch grant and target
// BUSY  | route granted master to target slave, count wait cycles
// ERR   | one-cycle error completion (timeout or unmapped target)
module uibi_interconnect #(
  parameter int XLEN        = 32,
  parameter int SLAVE_WIDTH = 4,
  parameter int N_MASTER    = 2,
  parameter int N_SLAVE     = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_MASTER*XLEN-1:0]              master_dat_i,
  output logic [N_MASTER*XLEN-1:0]              master_dat_o,
  input  logic [N_MASTER*(XLEN-SLAVE_WIDTH)-1:0] master_addr,
  input  logic [N_MASTER*SLAVE_WIDTH-1:0]       master_num,
  input  logic [N_MASTER-1:0]                   master_req,
  input  logic [N_MASTER-1:0]                   master_wen,
  input  logic [N_MASTER*3-1:0]                 master_mode,
  output logic [N_MASTER-1:0]                   master_ready,
  input  logic [N_SLAVE*XLEN-1:0]               slave_dat_i,
  output logic [N_SLAVE*XLEN-1:0]               slave_dat_o,
  output logic [N_SLAVE*(XLEN-SLAVE_WIDTH)-1:0] slave_addr,
  output logic [N_SLAVE-1:0]                    slave_req,
  output logic [N_SLAVE-1:0]                    slave_wen,
  output logic [N_SLAVE*3-1:0]                  slave_mode,
  input  logic [N_SLAVE-1:0]                    slave_ready,
  output logic                                  bus_err,
  output logic [2:0]                            err_master
);

  localparam int AW = XLEN - SLAVE_WIDTH;
  localparam int GW = $clog2(N_MASTER);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [GW-1:0]          grant, grant_nxt, last, last_nxt;
  logic [SLAVE_WIDTH-1:0] tgt, tgt_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [GW-1:0]          pick, idx;
  logic                   found;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(N_MASTER - 1);
      tgt   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      tgt   <= tgt_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    tgt_nxt   = tgt;
    cnt_nxt   = cnt;
    pick      = last;
    idx       = '0;
    found     = 1'b0;
    // search starts one past the last served master, wrapping around
    for (int i = 1; i <= N_MASTER; i++) begin
      idx = GW'((int'(last) + i) % N_MASTER);
      if (!found && master_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          tgt_nxt   = master_num[pick*SLAVE_WIDTH +: SLAVE_WIDTH];
          cnt_nxt   = '0;
          state_nxt = (int'(master_num[pick*SLAVE_WIDTH +: SLAVE_WIDTH]) < N_SLAVE) ? BUSY : ERR;
        end
      end
      BUSY: begin
        if (slave_ready[tgt] || !master_req[grant]) begin
          state_nxt = IDLE;
          last_nxt  = grant;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt_nxt == CW'(TIMEOUT)) state_nxt = ERR;
        end
      end
      ERR: begin
        state_nxt = IDLE;
        last_nxt  = grant;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    master_dat_o = '0;
    master_ready = '0;
    slave_dat_o  = '0;
    slave_addr   = '0;
    slave_req    = '0;
    slave_wen    = '0;
    slave_mode   = '0;
    bus_err      = 1'b0;
    err_master   = '0;
    case (state)
      BUSY: begin
        slave_req[tgt]                = master_req[grant];
        slave_wen[tgt]                = master_wen[grant];
        slave_addr[tgt*AW +: AW]      = master_addr[grant*AW +: AW];
        slave_mode[tgt*3 +: 3]        = master_mode[grant*3 +: 3];
        slave_dat_o[tgt*XLEN +: XLEN] = master_dat_i[grant*XLEN +: XLEN];
        master_ready[grant]             = slave_ready[tgt];
        master_dat_o[grant*XLEN +: XLEN] = slave_dat_i[tgt*XLEN +: XLEN];
      end
      ERR: begin
        master_ready[grant] = 1'b1;
        bus_err             = 1'b1;
        err_master          = 3'(grant);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/uibi_interconnect.md
Name: uibi_interconnect

Overview:
- Central switch of the unisys internal bus. Sits between N_MASTER bus masters (CPU fetch/LSU, DMA) and N_SLAVE bus slaves (memories, perf/peripheral blocks).
- Arbitrates master requests round-robin and routes the winner to the slave chosen by its bus_num.
- Returns the slave's read data and ready to the winner.
- Protects masters from hung or unmapped slaves with a timeout/error response.

Parameters:
- XLEN, 32, data width in bits.
- SLAVE_WIDTH, 4, width of bus_num; address width = XLEN-SLAVE_WIDTH.
- N_MASTER, 2, number of masters (2..8).
- N_SLAVE, 8, number of populated slaves (1..2**SLAVE_WIDTH); bus_num >= N_SLAVE is unmapped.
- TIMEOUT, 255, maximum cycles in BUSY waiting for slave ready before error completion.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- master_dat_i  in  N_MASTER*XLEN  write data from each master.
- master_dat_o  out  N_MASTER*XLEN  read data to each master.
- master_addr  in  N_MASTER*(XLEN-SLAVE_WIDTH)  per-master address.
- master_num  in  N_MASTER*SLAVE_WIDTH  per-master target slave number.
- master_req  in  N_MASTER  per-master request.
- master_wen  in  N_MASTER  per-master write enable.
- master_mode  in  N_MASTER*3  per-master byte-lane mode (111/011/001).
- master_ready  out  N_MASTER  per-master completion pulse.
- slave_dat_i  in  N_SLAVE*XLEN  read data from each slave.
- slave_dat_o  out  N_SLAVE*XLEN  write data to each slave.
- slave_addr  out  N_SLAVE*(XLEN-SLAVE_WIDTH)  address to each slave.
- slave_req  out  N_SLAVE  request to each slave.
- slave_wen  out  N_SLAVE  write enable to each slave.
- slave_mode  out  N_SLAVE*3  mode to each slave.
- slave_ready  in  N_SLAVE  per-slave completion.
- bus_err  out  1  one-cycle pulse on timeout or unmapped completion.
- err_master  out  3  index of the master that received the error; valid while bus_err=1.

Behaviour:
- Transaction protocol: a master holds req, addr, num, wen, mode and dat stable until it sees ready=1. Ready is high exactly one cycle per transaction. Read data is valid in that cycle.
- Reset values: state=IDLE, grant=0, last=N_MASTER-1, timeout counter=0. All master_ready, slave_req, slave_wen and bus_err are 0. All master_dat_o and slave_dat_o are 0. err_master=0.
- State IDLE:
  - If any master_req=1, pick the first requester searching from (last+1) mod N_MASTER upward with wrap. Register it as grant and its num as tgt; clear the counter.
  - Go to BUSY if tgt < N_SLAVE, else to ERR.
  - Arbitration costs exactly one cycle; no outputs are asserted in IDLE.
- State BUSY:
  - slave_req[tgt]=master_req[grant]. slave_addr, slave_wen, slave_mode and slave_dat_o of tgt are copied combinationally from master grant.
  - All other slaves see req=0, wen=0, data/addr/mode=0.
  - master_ready[grant]=slave_ready[tgt] and master_dat_o[grant]=slave_dat_i[tgt]. All other masters see ready=0, dat=0.
  - slave_ready[tgt]=1: go to IDLE next cycle and set last=grant.
  - master_req[grant] drops before ready (abort): slave_req drops the same cycle; go to IDLE and set last=grant.
  - Counter increments every BUSY cycle without ready. When counter reaches TIMEOUT, go to ERR; slave_req[tgt] is 0 from the next cycle.
  - Slave ready arriving in the same cycle the counter hits TIMEOUT: treat as normal completion, no error.
- State ERR (one cycle): master_ready[grant]=1, master_dat_o[grant]=0, bus_err=1, err_master=grant. No slave_req is asserted. Next state is IDLE with last=grant.
- Fairness:
  - A master is re-granted only after every other requesting master has been served once.
  - Back-to-back: each transaction costs arbitration cycle + slave latency (+0); minimum 2 cycles per transaction for a zero-wait slave.
- Idle slaves never see req. Mode and addr pass through unmodified; the interconnect does no byte-lane shifting.
- rst mid-transaction: next cycle state=IDLE, all slave_req=0, no ready or err pulse. A master still asserting req is re-arbitrated from last=N_MASTER-1, so master 0 wins first.
- Slave ready asserted while that slave is not targeted is ignored.

Test Plan:
- Single read: M0 req num=2, addr=0x10, wen=0; S2 ready after 3 cycles with dat 0x12345678 -> slave_req[2] high 3 cycles from cycle 1; master_ready[0] pulses once with master_dat_o[0]=0x12345678; S0/S1 req never high.
- Contention: M0 and M1 both req num=1 in the same cycle from reset -> M0 served first, then M1. With both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- Write with half mode: M1 wen=1, mode=011, dat=0xAABBCCDD, num=0 -> slave_wen[0]=1, slave_mode[0]=011, slave_dat_o[0]=0xAABBCCDD while slave_req[0] high.
- Timeout: TIMEOUT=4, S3 never ready -> slave_req[3] high exactly 4 cycles, then master_ready pulses with dat 0, bus_err=1, err_master=requester.
- Unmapped: N_SLAVE=8, M0 num=9 -> ERR the cycle after arbitration: ready pulse, dat 0, bus_err=1. No slave_req asserted at any time.
- Reset mid-BUSY: rst for 1 cycle during S1 wait -> slave_req[1]=0 next cycle, no ready/err pulse. M1 re-requesting is granted after the one-cycle arbitration.
